// File: rtl/lp805x_sched_pkg.sv
// Purpose : shared types and constants for the lp805x multi-channel scheduler.
// Latency : n/a (package only).
// Backpr.  : n/a (package only).
package lp805x_sched_pkg;

  // Per-channel FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_e;

  // Channel mode: one-shot stops after the first tick, continuous reloads.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  // Default parameter values shared by the top, the channel and the interface.
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_FACTOR_W = 9;
  localparam int DEF_INDEX_W  = 3;

endpackage

// File: rtl/lp805x_schedfs_mc_if.sv
// Purpose : bundle of control/status buses of the multi-channel scheduler.
// Latency : n/a (wiring only).
// Backpr.  : none; start is a strobe qualified by enable.
// Ports   : enable, start[CH], factor[CH*FW], mode[CH] in;
//           index[CH*IW], index_vld[CH], tick[CH], busy[CH] out.
interface lp805x_schedfs_mc_if
  import lp805x_sched_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FACTOR_W = DEF_FACTOR_W,
  parameter int INDEX_W  = DEF_INDEX_W
) ();

  logic                         enable;
  logic [CHANNELS-1:0]          start;
  logic [CHANNELS*FACTOR_W-1:0] factor;
  logic [CHANNELS-1:0]          mode;
  logic [CHANNELS*INDEX_W-1:0]  index;
  logic [CHANNELS-1:0]          index_vld;
  logic [CHANNELS-1:0]          tick;
  logic [CHANNELS-1:0]          busy;

  // Controller side.
  modport master (
    output enable, start, factor, mode,
    input  index, index_vld, tick, busy
  );

  // Scheduler side.
  modport slave (
    input  enable, start, factor, mode,
    output index, index_vld, tick, busy
  );

endinterface

// File: rtl/lp805x_schedfs_chan.sv
// Purpose : one scheduler channel: log2 of the factor, then a periodic/one-shot tick.
// Latency : index after floor(log2(max(f,1)))+1 cycles; first tick max(f,1) cycles later.
// Backpr.  : none; enable=0 freezes all state and suppresses tick and start.
// Ports   : clk, rst, enable, start, factor, mode in; index, index_vld, tick, busy out.
module lp805x_schedfs_chan
  import lp805x_sched_pkg::*;
#(
  parameter int FACTOR_W = DEF_FACTOR_W,
  parameter int INDEX_W  = DEF_INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic [FACTOR_W-1:0] factor,
  input  logic                mode,
  output logic [INDEX_W-1:0]  index,
  output logic                index_vld,
  output logic                tick,
  output logic                busy
);

  // Shift counter must hold FACTOR_W-1 and be at least INDEX_W wide for the slice.
  localparam int SHC_RAW = $clog2(FACTOR_W) + 1;
  localparam int SHC_W   = (SHC_RAW > INDEX_W) ? SHC_RAW : INDEX_W;
  localparam int IDX_MAX = (1 << INDEX_W) - 1;

  sched_state_e        state_q, state_d;
  logic [FACTOR_W-1:0] shv_q, shv_d;      // value being shifted down in CALC
  logic [SHC_W-1:0]    shc_q, shc_d;      // number of shifts so far
  logic [FACTOR_W-1:0] per_q, per_d;      // reload value max(factor,1)-1
  logic [FACTOR_W-1:0] cnt_q, cnt_d;      // period down-counter
  logic                mode_q, mode_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic                index_vld_q, index_vld_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    shv_d       = shv_q;
    shc_d       = shc_q;
    per_d       = per_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    index_d     = index_q;
    index_vld_d = index_vld_q;
    tick_d      = 1'b0;

    if (enable) begin
      if (start) begin
        // A start always wins, including over a pending tick at count 0.
        shv_d       = factor;
        shc_d       = '0;
        per_d       = (factor == '0) ? '0 : factor - FACTOR_W'(1);
        mode_d      = mode;
        index_vld_d = 1'b0;
        state_d     = ST_CALC;
      end else begin
        case (state_q)
          ST_CALC: begin
            if (shv_q > FACTOR_W'(1)) begin
              shv_d = shv_q >> 1;
              shc_d = shc_q + SHC_W'(1);
            end else begin
              if (shc_q > SHC_W'(IDX_MAX)) begin
                index_d = INDEX_W'(IDX_MAX);
              end else begin
                index_d = shc_q[INDEX_W-1:0];
              end
              index_vld_d = 1'b1;
              cnt_d       = per_q;
              state_d     = ST_RUN;
            end
          end
          ST_RUN: begin
            if (cnt_q == '0) begin
              tick_d = 1'b1;
              if (mode_q == MODE_CONT) begin
                cnt_d = per_q;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - FACTOR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shv_q       <= '0;
      shc_q       <= '0;
      per_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_ONESHOT;
      index_q     <= '0;
      index_vld_q <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shv_q       <= shv_d;
      shc_q       <= shc_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      index_q     <= index_d;
      index_vld_q <= index_vld_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
    end
  end

  assign index     = index_q;
  assign index_vld = index_vld_q;
  assign tick      = tick_q;
  assign busy      = busy_q;

endmodule

// File: rtl/lp805x_schedfs_mc.sv
// Purpose : CHANNELS independent log2-scaled tick schedulers behind one bus interface.
// Latency : per channel, see lp805x_schedfs_chan; all outputs registered.
// Backpr.  : none; global enable freezes every channel.
// Ports   : clk, rst (sync, active-high); bus (lp805x_schedfs_mc_if.slave).
module lp805x_schedfs_mc
  import lp805x_sched_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FACTOR_W = DEF_FACTOR_W,
  parameter int INDEX_W  = DEF_INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  lp805x_schedfs_mc_if.slave  bus
);

  wire [CHANNELS*INDEX_W-1:0] index_w;
  wire [CHANNELS-1:0]         index_vld_w;
  wire [CHANNELS-1:0]         tick_w;
  wire [CHANNELS-1:0]         busy_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    lp805x_schedfs_chan #(
      .FACTOR_W (FACTOR_W),
      .INDEX_W  (INDEX_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .enable    (bus.enable),
      .start     (bus.start[c]),
      .factor    (bus.factor[c*FACTOR_W +: FACTOR_W]),
      .mode      (bus.mode[c]),
      .index     (index_w[c*INDEX_W +: INDEX_W]),
      .index_vld (index_vld_w[c]),
      .tick      (tick_w[c]),
      .busy      (busy_w[c])
    );
  end

  assign bus.index     = index_w;
  assign bus.index_vld = index_vld_w;
  assign bus.tick      = tick_w;
  assign bus.busy      = busy_w;

endmodule

// File: tb/tb_lp805x_schedfs_mc.sv
// Purpose : self-checking bench for lp805x_schedfs_mc against an arithmetic reference.
// Latency : n/a.
// Backpr.  : n/a.
module tb_lp805x_schedfs_mc;

  localparam int CH = 2;
  localparam int FW = 9;
  localparam int IW = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lp805x_schedfs_mc_if #(.CHANNELS(CH), .FACTOR_W(FW), .INDEX_W(IW)) bus ();

  lp805x_schedfs_mc #(.CHANNELS(CH), .FACTOR_W(FW), .INDEX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Position of the highest set bit (0 for 0 and 1).
  function automatic int flog2(input int f);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) if (f >= (1 << b)) r = b;
    return r;
  endfunction

  function automatic int exp_index(input int f);
    int l;
    l = flog2(f);
    return (l > (1 << IW) - 1) ? (1 << IW) - 1 : l;
  endfunction

  function automatic int exp_lat(input int f);
    return flog2(f) + 1;
  endfunction

  function automatic int exp_period(input int f);
    return (f < 1) ? 1 : f;
  endfunction

  function automatic int idx_of(input int ch);
    return int'(bus.index[ch*IW +: IW]);
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic do_start(input logic [1:0] mask, input int f0, input int f1,
                          input logic m0, input logic m1);
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    a = f0[FW-1:0];
    b = f1[FW-1:0];
    if (mask[0]) begin bus.factor[0 +: FW] = a; bus.mode[0] = m0; end
    if (mask[1]) begin bus.factor[FW +: FW] = b; bus.mode[1] = m1; end
    bus.start = mask;
    @(negedge clk);
    bus.start = '0;
  endtask

  // Cycles until index_vld rises on the masked channels; -1 if it never does.
  task automatic wait_rise(input logic [1:0] mask, output int r0, output int r1);
    r0 = mask[0] ? -1 : 0;
    r1 = mask[1] ? -1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (r0 < 0 && bus.index_vld[0]) r0 = n;
      if (r1 < 0 && bus.index_vld[1]) r1 = n;
      if (r0 >= 0 && r1 >= 0) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.start  = '1;
    repeat (3) @(negedge clk);
    bus.start = '0;
    n_checks++; if (bus.index !== '0) begin n_fail++; $display("FAIL reset_index got %h want 0", bus.index); end
    n_checks++; if (bus.index_vld !== '0) begin n_fail++; $display("FAIL reset_vld got %b want 0", bus.index_vld); end
    n_checks++; if (bus.tick !== '0) begin n_fail++; $display("FAIL reset_tick got %b want 0", bus.tick); end
    n_checks++; if (bus.busy !== '0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_factor_index();
    int fl[6] = '{5, 8, 15, 30, 250, 501};
    int r0, r1;
    for (int i = 0; i < 6; i++) begin
      do_start(2'b01, fl[i], 0, 1'b1, 1'b0);
      n_checks++; if (bus.index_vld[0] !== 1'b0) begin n_fail++; $display("FAIL fi_vld_clear f=%0d got %b want 0", fl[i], bus.index_vld[0]); end
      n_checks++; if (bus.busy[0] !== 1'b1) begin n_fail++; $display("FAIL fi_busy f=%0d got %b want 1", fl[i], bus.busy[0]); end
      wait_rise(2'b01, r0, r1);
      n_checks++; if (r0 != exp_lat(fl[i])) begin n_fail++; $display("FAIL fi_latency f=%0d got %0d want %0d", fl[i], r0, exp_lat(fl[i])); end
      n_checks++; if (idx_of(0) != exp_index(fl[i])) begin n_fail++; $display("FAIL fi_index f=%0d got %0d want %0d", fl[i], idx_of(0), exp_index(fl[i])); end
    end
  endtask

  task automatic test_random();
    int f0, f1, r0, r1, t0, t1;
    logic m0, m1;
    for (int it = 0; it < 6; it++) begin
      f0 = (it == 0) ? 0 : ((it == 1) ? 1 : int'($urandom_range(0, 511)));
      f1 = int'($urandom_range(0, 511));
      m0 = 1'($urandom_range(0, 1));
      m1 = 1'($urandom_range(0, 1));
      do_start(2'b11, f0, f1, m0, m1);
      r0 = -1; r1 = -1; t0 = -1; t1 = -1;
      for (int n = 1; n <= 600; n++) begin
        @(negedge clk);
        if (r0 < 0 && bus.index_vld[0]) begin
          r0 = n;
          n_checks++; if (idx_of(0) != exp_index(f0)) begin n_fail++; $display("FAIL rnd_index0 f=%0d got %0d want %0d", f0, idx_of(0), exp_index(f0)); end
        end
        if (r1 < 0 && bus.index_vld[1]) begin
          r1 = n;
          n_checks++; if (idx_of(1) != exp_index(f1)) begin n_fail++; $display("FAIL rnd_index1 f=%0d got %0d want %0d", f1, idx_of(1), exp_index(f1)); end
        end
        if (t0 < 0 && bus.tick[0]) t0 = n;
        if (t1 < 0 && bus.tick[1]) t1 = n;
        if (t0 >= 0 && t1 >= 0) break;
      end
      n_checks++; if (r0 != exp_lat(f0)) begin n_fail++; $display("FAIL rnd_lat0 f=%0d got %0d want %0d", f0, r0, exp_lat(f0)); end
      n_checks++; if (r1 != exp_lat(f1)) begin n_fail++; $display("FAIL rnd_lat1 f=%0d got %0d want %0d", f1, r1, exp_lat(f1)); end
      n_checks++; if (t0 - r0 != exp_period(f0)) begin n_fail++; $display("FAIL rnd_tick0 f=%0d got %0d want %0d", f0, t0 - r0, exp_period(f0)); end
      n_checks++; if (t1 - r1 != exp_period(f1)) begin n_fail++; $display("FAIL rnd_tick1 f=%0d got %0d want %0d", f1, t1 - r1, exp_period(f1)); end
    end
  endtask

  task automatic test_continuous();
    int r0, r1, busy_lo;
    int q[$];
    do_start(2'b01, 8, 0, 1'b1, 1'b0);
    bus.factor[0 +: FW] = 9'd3;  // change without start must be ignored
    wait_rise(2'b01, r0, r1);
    n_checks++; if (r0 != 4) begin n_fail++; $display("FAIL cont_latency got %0d want 4", r0); end
    busy_lo = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (bus.tick[0]) q.push_back(t);
      if (!bus.busy[0]) busy_lo++;
    end
    n_checks++; if (q.size() != 5) begin n_fail++; $display("FAIL cont_tick_count got %0d want 5", q.size()); end
    n_checks++; if (busy_lo != 0) begin n_fail++; $display("FAIL cont_busy got %0d idle cycles want 0", busy_lo); end
    for (int i = 0; i < q.size(); i++) begin
      n_checks++; if (q[i] != 8 * (i + 1)) begin n_fail++; $display("FAIL cont_tick_time #%0d got %0d want %0d", i, q[i], 8 * (i + 1)); end
    end
  endtask

  task automatic test_oneshot();
    int r0, r1;
    int q[$];
    do_start(2'b01, 4, 0, 1'b0, 1'b0);
    wait_rise(2'b01, r0, r1);
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (bus.tick[0]) q.push_back(t);
    end
    n_checks++; if (q.size() != 1) begin n_fail++; $display("FAIL os_tick_count got %0d want 1", q.size()); end
    if (q.size() > 0) begin
      n_checks++; if (q[0] != 4) begin n_fail++; $display("FAIL os_tick_time got %0d want 4", q[0]); end
    end
    n_checks++; if (bus.busy[0] !== 1'b0) begin n_fail++; $display("FAIL os_busy got %b want 0", bus.busy[0]); end
    n_checks++; if (bus.index_vld[0] !== 1'b1) begin n_fail++; $display("FAIL os_vld got %b want 1", bus.index_vld[0]); end
    n_checks++; if (idx_of(0) != 2) begin n_fail++; $display("FAIL os_index got %0d want 2", idx_of(0)); end
  endtask

  task automatic test_freeze();
    int r0, r1, frz_ticks;
    int q[$];
    do_start(2'b01, 8, 0, 1'b1, 1'b0);
    wait_rise(2'b01, r0, r1);
    frz_ticks = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (bus.tick[0]) q.push_back(t);
      if (t >= 12 && t <= 21 && bus.tick[0]) frz_ticks++;
      if (t == 11) begin
        bus.enable = 1'b0;
        bus.factor[0 +: FW] = 9'd3;
        bus.start[0] = 1'b1;
      end
      if (t == 21) begin
        bus.start[0] = 1'b0;
        n_checks++; if (bus.index_vld[0] !== 1'b1) begin n_fail++; $display("FAIL frz_vld got %b want 1", bus.index_vld[0]); end
        n_checks++; if (idx_of(0) != 3) begin n_fail++; $display("FAIL frz_index got %0d want 3", idx_of(0)); end
        bus.enable = 1'b1;
      end
    end
    n_checks++; if (frz_ticks != 0) begin n_fail++; $display("FAIL frz_no_tick got %0d want 0", frz_ticks); end
    n_checks++; if (q.size() < 2 || q[0] != 8 || q[1] != 26) begin
      n_fail++; $display("FAIL frz_tick_times got n=%0d t0=%0d t1=%0d want 8 26", q.size(),
                         (q.size() > 0) ? q[0] : -1, (q.size() > 1) ? q[1] : -1);
    end
  endtask

  task automatic test_collision();
    int r0, r1;
    do_start(2'b01, 8, 0, 1'b1, 1'b0);
    wait_rise(2'b01, r0, r1);
    repeat (7) @(negedge clk);
    // Counter is 0 now: the next edge would tick without the start.
    do_start(2'b01, 70, 0, 1'b1, 1'b0);
    n_checks++; if (bus.tick[0] !== 1'b0) begin n_fail++; $display("FAIL col_tick got %b want 0", bus.tick[0]); end
    n_checks++; if (bus.index_vld[0] !== 1'b0) begin n_fail++; $display("FAIL col_vld got %b want 0", bus.index_vld[0]); end
    wait_rise(2'b01, r0, r1);
    n_checks++; if (r0 != 7) begin n_fail++; $display("FAIL col_latency got %0d want 7", r0); end
    n_checks++; if (idx_of(0) != 6) begin n_fail++; $display("FAIL col_index got %0d want 6", idx_of(0)); end
  endtask

  task automatic test_reset_midrun();
    int r0, r1;
    do_start(2'b11, 5, 32, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++; if (bus.busy !== 2'b11) begin n_fail++; $display("FAIL rmr_busy_before got %b want 11", bus.busy); end
    rst = 1'b1;
    bus.start = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    bus.start = '0;
    n_checks++; if (bus.index !== '0) begin n_fail++; $display("FAIL rmr_index got %h want 0", bus.index); end
    n_checks++; if (bus.index_vld !== '0) begin n_fail++; $display("FAIL rmr_vld got %b want 0", bus.index_vld); end
    n_checks++; if (bus.tick !== '0) begin n_fail++; $display("FAIL rmr_tick got %b want 0", bus.tick); end
    n_checks++; if (bus.busy !== '0) begin n_fail++; $display("FAIL rmr_busy got %b want 0", bus.busy); end
    do_start(2'b11, 5, 32, 1'b1, 1'b1);
    wait_rise(2'b11, r0, r1);
    n_checks++; if (r0 != exp_lat(5)) begin n_fail++; $display("FAIL rmr_lat0 got %0d want %0d", r0, exp_lat(5)); end
    n_checks++; if (r1 != exp_lat(32)) begin n_fail++; $display("FAIL rmr_lat1 got %0d want %0d", r1, exp_lat(32)); end
    n_checks++; if (idx_of(0) != 2) begin n_fail++; $display("FAIL rmr_index0 got %0d want 2", idx_of(0)); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.start  = '0;
    bus.factor = '0;
    bus.mode   = '0;
    @(negedge clk);
    test_reset();
    test_factor_index();
    test_random();
    test_continuous();
    test_oneshot();
    test_freeze();
    test_collision();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
